// File: rtl/vga_rx_timing.sv
// Sink-side 640x480 VGA timing recovery: rebuilds x/y from the sync edges, checks the sync
// timing, declares lock after clean frames and emits qualified pixels.
module vga_rx_timing #(
   parameter int unsigned HPIXELS     = 800,
   parameter int unsigned VLINES      = 521,
   parameter int unsigned HPULSE      = 96,
   parameter int unsigned VPULSE      = 2,
   parameter int unsigned HBP         = 144,
   parameter int unsigned HFP         = 784,
   parameter int unsigned VBP         = 31,
   parameter int unsigned VFP         = 511,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic       dclk,
   input  logic       clr,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic [2:0] red_in,
   input  logic [2:0] green_in,
   input  logic [1:0] blue_in,
   output logic [9:0] x,
   output logic [8:0] y,
   output logic [7:0] pixel,
   output logic       pixel_valid,
   output logic       frame_start,
   output logic       locked,
   output logic       hsync_err,
   output logic       vsync_err,
   output logic [9:0] line_len,
   output logic [9:0] frame_lines
);

   localparam logic [9:0] CNT_MAX   = 10'd1023;
   localparam logic [9:0] H_LAST    = 10'(HPIXELS - 1);
   localparam logic [9:0] H_PW_LAST = 10'(HPULSE - 1);
   localparam logic [9:0] V_LAST    = 10'(VLINES - 1);
   localparam logic [9:0] V_PW_LAST = 10'(VPULSE - 1);
   localparam logic [9:0] H_BP      = 10'(HBP);
   localparam logic [9:0] H_FP      = 10'(HFP);
   localparam logic [9:0] V_BP      = 10'(VBP);
   localparam logic [9:0] V_FP      = 10'(VFP);

   typedef enum logic [1:0] {StSearch, StVerify, StLocked} lock_state_e;

   lock_state_e state_q, state_d;
   logic [7:0]  good_q, good_d;
   logic        hs1_q, vs1_q, hs2_q, vs2_q;
   logic [7:0]  rgb1_q, rgb2_q;
   logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic        h_armed_q, h_armed_d, v_armed_q, v_armed_d;
   logic        h_fall, h_rise, v_fall, v_rise;
   logic        h_sat, h_err, v_err, err;
   logic        in_win, valid_d;

   function automatic logic [9:0] sat_inc(input logic [9:0] v);
      return (v == CNT_MAX) ? v : v + 10'd1;
   endfunction

   // Syncs idle high out of reset so release cannot fake an edge.
   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         hs1_q  <= 1'b1;
         vs1_q  <= 1'b1;
         hs2_q  <= 1'b1;
         vs2_q  <= 1'b1;
         rgb1_q <= 8'd0;
         rgb2_q <= 8'd0;
      end else begin
         hs1_q  <= hsync_in;
         vs1_q  <= vsync_in;
         rgb1_q <= {red_in, green_in, blue_in};
         hs2_q  <= hs1_q;
         vs2_q  <= vs1_q;
         rgb2_q <= rgb1_q;
      end
   end

   assign h_fall = hs2_q & ~hs1_q;
   assign h_rise = ~hs2_q & hs1_q;
   assign v_fall = vs2_q & ~vs1_q;
   assign v_rise = ~vs2_q & vs1_q;

   always_comb begin
      hcnt_d = sat_inc(hcnt_q);
      if (h_fall) hcnt_d = 10'd0;
      vcnt_d = vcnt_q;
      if (v_fall) vcnt_d = 10'd0;
      else if (h_fall) vcnt_d = sat_inc(vcnt_q);

      // Fires once on the climb into saturation, not while parked there.
      h_sat = ~h_fall & (hcnt_q == CNT_MAX - 10'd1);
      h_err = h_sat | (h_armed_q & h_fall & (hcnt_q != H_LAST))
                    | (h_armed_q & h_rise & (hcnt_q != H_PW_LAST));
      v_err = v_armed_q & ((v_fall & (~h_fall | (vcnt_q != V_LAST)))
                         | (v_rise & (~h_fall | (vcnt_q != V_PW_LAST))));
      err   = h_err | v_err;

      h_armed_d = h_armed_q | h_fall;
      if (h_err) h_armed_d = 1'b0;
      v_armed_d = v_armed_q | v_fall;
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      case (state_q)
         StSearch: begin
            if (v_fall && !err) begin
               state_d = StVerify;
               good_d  = 8'd0;
            end
         end
         StVerify: begin
            if (err) state_d = StSearch;
            else if (v_fall) begin
               if (({24'd0, good_q} + 32'd1) >= LOCK_FRAMES) state_d = StLocked;
               else good_d = good_q + 8'd1;
            end
         end
         StLocked: begin
            if (err) state_d = StSearch;
         end
         default: state_d = StSearch;
      endcase
   end

   // Qualify on the next lock state so pixels stop in the same cycle lock drops.
   assign in_win  = (hcnt_q >= H_BP) && (hcnt_q < H_FP) && (vcnt_q >= V_BP) && (vcnt_q < V_FP);
   assign valid_d = (state_d == StLocked) && in_win;

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         state_q     <= StSearch;
         good_q      <= 8'd0;
         hcnt_q      <= 10'd0;
         vcnt_q      <= 10'd0;
         h_armed_q   <= 1'b0;
         v_armed_q   <= 1'b0;
         x           <= 10'd0;
         y           <= 9'd0;
         pixel       <= 8'd0;
         pixel_valid <= 1'b0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         hsync_err   <= 1'b0;
         vsync_err   <= 1'b0;
         line_len    <= 10'd0;
         frame_lines <= 10'd0;
      end else begin
         state_q     <= state_d;
         good_q      <= good_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         h_armed_q   <= h_armed_d;
         v_armed_q   <= v_armed_d;
         x           <= valid_d ? hcnt_q - H_BP : 10'd0;
         y           <= valid_d ? 9'(vcnt_q - V_BP) : 9'd0;
         pixel       <= valid_d ? rgb2_q : 8'd0;
         pixel_valid <= valid_d;
         frame_start <= valid_d && (hcnt_q == H_BP) && (vcnt_q == V_BP);
         locked      <= (state_d == StLocked);
         hsync_err   <= h_err;
         vsync_err   <= v_err;
         if (h_fall) line_len <= sat_inc(hcnt_q);
         if (v_fall) frame_lines <= sat_inc(vcnt_q);
      end
   end

endmodule

// File: tb/tb_vga_rx_timing.sv
// Directed bench for vga_rx_timing: a sync generator drives the DUT, expectations are queued
// with the cycle they become due and compared as the DUT produces them.
module tb_vga_rx_timing;

   // Scaled-down timing keeps full-frame lock sequences short.
   localparam int HP = 40, VL = 12, HPW = 6, VPW = 2;
   localparam int HB = 10, HF = 34, VB = 3, VF = 10, LF = 2;

   logic       dclk = 1'b0, clr = 1'b1;
   logic       hsync_in = 1'b1, vsync_in = 1'b1;
   logic [2:0] red_in = 3'd0, green_in = 3'd0;
   logic [1:0] blue_in = 2'd0;
   logic [9:0] x, line_len, frame_lines;
   logic [8:0] y;
   logic [7:0] pixel;
   logic       pixel_valid, frame_start, locked, hsync_err, vsync_err;

   vga_rx_timing #(
      .HPIXELS(HP), .VLINES(VL), .HPULSE(HPW), .VPULSE(VPW), .HBP(HB), .HFP(HF),
      .VBP(VB), .VFP(VF), .LOCK_FRAMES(LF)
   ) dut (
      .dclk(dclk), .clr(clr), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .x(x), .y(y), .pixel(pixel), .pixel_valid(pixel_valid), .frame_start(frame_start),
      .locked(locked), .hsync_err(hsync_err), .vsync_err(vsync_err),
      .line_len(line_len), .frame_lines(frame_lines)
   );

   always #20 dclk = ~dclk;

   typedef enum {SigLocked, SigValid, SigX, SigY, SigPixel, SigFs, SigHerr, SigVerr,
                 SigLineLen, SigFrameLines} sig_e;
   typedef struct {int due; sig_e sig; logic [31:0] exp; string tag;} chk_t;

   chk_t sb[$];
   int   cyc = 0, vectors = 0, miscompares = 0;
   int   gen_hc = 0, gen_vc = 0, hlen = HP, hpw = HPW, vpw = VPW;

   function automatic logic [31:0] obs(sig_e s);
      case (s)
         SigLocked:     return {31'd0, locked};
         SigValid:      return {31'd0, pixel_valid};
         SigX:          return {22'd0, x};
         SigY:          return {23'd0, y};
         SigPixel:      return {24'd0, pixel};
         SigFs:         return {31'd0, frame_start};
         SigHerr:       return {31'd0, hsync_err};
         SigVerr:       return {31'd0, vsync_err};
         SigLineLen:    return {22'd0, line_len};
         SigFrameLines: return {22'd0, frame_lines};
         default:       return 32'hdead_beef;
      endcase
   endfunction

   task automatic compare(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_abs(input int due, input sig_e s, input logic [31:0] v, input string tag);
      sb.push_back('{due, s, v, tag});
   endtask

   // off counts cycles from the drive of the next generator sample.
   task automatic expect_at(input int off, input sig_e s, input logic [31:0] v,
                            input string tag);
      push_abs(cyc + 1 + off, s, v, tag);
   endtask

   task automatic tick(input bit frozen);
      @(negedge dclk);
      cyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            compare(sb[i].tag, obs(sb[i].sig), sb[i].exp);
            sb.delete(i);
         end
      end
      if (frozen) begin
         hsync_in = 1'b1;
         vsync_in = 1'b1;
         {red_in, green_in, blue_in} = 8'd0;
      end else begin
         hsync_in = !(gen_hc < hpw);
         vsync_in = !(gen_vc < vpw);
         {red_in, green_in, blue_in} = 8'(gen_hc);
         gen_hc++;
         if (gen_hc == hlen) begin
            gen_hc = 0;
            gen_vc++;
            if (gen_vc == VL) gen_vc = 0;
         end
      end
   endtask

   // Drive until the next sample to be driven is (v, h).
   task automatic advance_to(input int v, input int h);
      int n = 0;
      do begin
         tick(1'b0);
         n++;
      end while (!(gen_vc == v && gen_hc == h) && n < 20000);
      if (n >= 20000) begin
         miscompares++;
         $display("FAIL advance_bound: generator did not reach %0d,%0d", v, h);
      end
   endtask

   // Next sample is the 2nd frame start since SEARCH; lock must follow the 3rd.
   task automatic expect_lock(input string tag);
      expect_at(2, SigLocked, 0, {tag, "_still_unlocked"});
      advance_to(0, 0);
      expect_at(1, SigLocked, 0, {tag, "_lock_pre"});
      expect_at(2, SigLocked, 1, {tag, "_lock"});
      expect_at(2, SigFrameLines, VL, {tag, "_frame_lines"});
      expect_at(2, SigLineLen, HP, {tag, "_line_len"});
   endtask

   task automatic relock(input string tag);
      advance_to(0, 0);
      advance_to(0, 0);
      expect_lock(tag);
   endtask

   initial begin
      int d0;
      // Reset state
      repeat (3) @(negedge dclk);
      compare("rst_locked", {31'd0, locked}, 0);
      compare("rst_valid", {31'd0, pixel_valid}, 0);
      compare("rst_line_len", {22'd0, line_len}, 0);
      compare("rst_pixel", {24'd0, pixel}, 0);
      clr = 1'b0;

      // 1: ideal stream, lock and first pixel
      advance_to(0, 0);
      expect_lock("t1");
      advance_to(VB, HB - 1);
      expect_at(3, SigValid, 0, "t1_pre_valid");
      expect_at(3, SigPixel, 0, "t1_pre_pixel");
      advance_to(VB, HB);
      expect_at(3, SigValid, 1, "t1_first_valid");
      expect_at(3, SigX, 0, "t1_first_x");
      expect_at(3, SigY, 0, "t1_first_y");
      expect_at(3, SigPixel, HB, "t1_first_pixel");
      expect_at(3, SigFs, 1, "t1_frame_start");
      expect_at(4, SigFs, 0, "t1_frame_start_pulse");
      expect_at(4, SigX, 1, "t1_second_x");
      advance_to(VF - 1, HF - 1);
      expect_at(3, SigX, HF - HB - 1, "t1_last_x");
      expect_at(3, SigY, VF - VB - 1, "t1_last_y");
      expect_at(3, SigPixel, HF - 1, "t1_last_pixel");
      expect_at(4, SigValid, 0, "t1_past_active");
      expect_at(4, SigX, 0, "t1_past_x");

      // 2: narrow hsync pulse while locked
      advance_to(5, 0);
      hpw = HPW - 1;
      advance_to(5, HPW - 1);
      expect_at(1, SigHerr, 0, "t2_herr_pre");
      expect_at(1, SigLocked, 1, "t2_locked_pre");
      expect_at(2, SigHerr, 1, "t2_herr");
      expect_at(2, SigLocked, 0, "t2_unlocked");
      expect_at(2, SigValid, 0, "t2_valid");
      expect_at(3, SigHerr, 0, "t2_herr_pulse");
      advance_to(5, 20);
      hpw = HPW;
      expect_at(3, SigValid, 0, "t2_active_unlocked");
      relock("t2");

      // 3: one line a cycle too long
      advance_to(7, 0);
      hlen = HP + 1;
      advance_to(8, 0);
      hlen = HP;
      expect_at(1, SigLocked, 1, "t3_locked_pre");
      expect_at(2, SigHerr, 1, "t3_herr");
      expect_at(2, SigLineLen, HP + 1, "t3_line_len");
      expect_at(2, SigLocked, 0, "t3_unlocked");
      relock("t3");

      // 4: vsync held low for three lines
      vpw = VPW + 1;
      advance_to(VPW + 1, 0);
      vpw = VPW;
      expect_at(1, SigVerr, 0, "t4_verr_pre");
      expect_at(2, SigVerr, 1, "t4_verr");
      expect_at(2, SigLocked, 0, "t4_unlocked");
      expect_at(2, SigHerr, 0, "t4_no_herr");
      expect_at(3, SigVerr, 0, "t4_verr_pulse");
      relock("t4");

      // 5: syncs stuck high, hcnt saturates
      advance_to(5, 0);
      d0 = cyc + 1;
      advance_to(5, 20);
      push_abs(d0 + 1024, SigHerr, 0, "t5_herr_pre");
      push_abs(d0 + 1024, SigLocked, 1, "t5_locked_pre");
      push_abs(d0 + 1025, SigHerr, 1, "t5_herr_sat");
      push_abs(d0 + 1025, SigLocked, 0, "t5_unlocked");
      push_abs(d0 + 1026, SigHerr, 0, "t5_herr_once");
      push_abs(d0 + 1800, SigHerr, 0, "t5_herr_quiet");
      repeat (2000) tick(1'b1);
      advance_to(6, 0);
      expect_at(2, SigHerr, 0, "t5_herr_on_return");
      expect_at(2, SigLineLen, 1023, "t5_line_len_sat");
      relock("t5");

      // 6: clr mid active area
      advance_to(5, 20);
      compare("t6_pre_locked", {31'd0, locked}, 1);
      compare("t6_pre_valid", {31'd0, pixel_valid}, 1);
      compare("t6_pre_x", {22'd0, x}, 6);
      compare("t6_pre_y", {23'd0, y}, 5 - VB);
      clr = 1'b1;
      #1;
      compare("t6_clr_locked", {31'd0, locked}, 0);
      compare("t6_clr_valid", {31'd0, pixel_valid}, 0);
      compare("t6_clr_x", {22'd0, x}, 0);
      compare("t6_clr_y", {23'd0, y}, 0);
      compare("t6_clr_pixel", {24'd0, pixel}, 0);
      compare("t6_clr_line_len", {22'd0, line_len}, 0);
      compare("t6_clr_frame_lines", {22'd0, frame_lines}, 0);
      tick(1'b0);
      tick(1'b0);
      clr = 1'b0;
      for (int k = 0; k < 6; k++) begin
         expect_at(k, SigHerr, 0, "t6_release_herr");
         expect_at(k, SigVerr, 0, "t6_release_verr");
         expect_at(k, SigLocked, 0, "t6_release_locked");
      end
      relock("t6");

      repeat (8) tick(1'b0);
      compare("scoreboard_drained", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
